// File: rtl/fb_access_sequencer.sv
// Frame-buffer access sequencer: debounced capture request, one-frame write window,
// then a display-read hold-off until raster and read FIFO are back at origin.
`timescale 1ns/1ps
module fb_access_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4096,
  parameter int unsigned FB_WORDS        = 65536,
  parameter int unsigned SYNC_TIMEOUT    = 1048576,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_req,
  input  logic              pix_valid,
  input  logic [ADDR_W-1:0] vga_x,
  input  logic [ADDR_W-1:0] vga_y,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic              rd_gate,
  output logic              rd_load,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned WORD_W = ADDR_W + 1;
  localparam int unsigned TO_W   = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FB_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_DISPLAY = 3'd0,
    S_ARM     = 3'd1,
    S_WRITE   = 3'd2,
    S_RESYNC  = 3'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sync;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [WORD_W-1:0] r_word_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [7:0]        r_frame_cnt;
  logic              r_rd_gate;
  logic              r_rd_load;
  logic              r_busy;
  logic              r_sync_err;

  logic w_req_s;
  logic w_wr_en;
  logic w_at_origin;

  assign w_req_s     = r_sync[1];
  assign w_wr_en     = pix_valid & (r_state == S_WRITE);
  assign w_at_origin = (vga_x == '0) && (vga_y == '0) && (rd_addr == '0);

  // Sequencer FSM; rd_gate/busy are updated together with every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_DISPLAY;
      r_sync      <= 2'b00;
      r_deb_cnt   <= '0;
      r_word_cnt  <= '0;
      r_to_cnt    <= '0;
      r_frame_cnt <= 8'd0;
      r_rd_gate   <= 1'b1;
      r_rd_load   <= 1'b0;
      r_busy      <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], cap_req};
      r_rd_load <= 1'b0;
      case (r_state)
        S_DISPLAY: begin
          if (w_req_s) begin
            r_state   <= S_ARM;
            r_deb_cnt <= '0;
            r_rd_gate <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_ARM: begin
          if (w_req_s) begin
            if (r_deb_cnt != DEB_LAST) r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end else if (r_deb_cnt == DEB_LAST) begin
            // Capture starts on release of a request held long enough.
            r_state    <= S_WRITE;
            r_word_cnt <= '0;
          end else begin
            r_state   <= S_DISPLAY;
            r_rd_gate <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        S_WRITE: begin
          if (w_wr_en) begin
            r_word_cnt <= r_word_cnt + WORD_W'(1);
            if (r_word_cnt == WORD_LAST) begin
              r_state     <= S_RESYNC;
              r_to_cnt    <= '0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        S_RESYNC: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_at_origin || (r_to_cnt == TO_LAST)) begin
            r_state   <= S_DISPLAY;
            r_rd_load <= 1'b1;
            r_rd_gate <= 1'b1;
            r_busy    <= 1'b0;
            if (!w_at_origin) r_sync_err <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_DISPLAY;
          r_rd_gate <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en     = w_wr_en;
  assign rd_gate   = r_rd_gate;
  assign rd_load   = r_rd_load;
  assign busy      = r_busy;
  assign state_o   = r_state;
  assign frame_cnt = r_frame_cnt;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_fb_access_sequencer.sv
// Randomized bench for fb_access_sequencer: captures are predicted per transaction
// from hold length, pixel strobes and origin arrival time.
`timescale 1ns/1ps
module tb_fb_access_sequencer;

  localparam int unsigned DEB = 16;
  localparam int unsigned FB  = 64;
  localparam int unsigned TO  = 32;
  localparam int unsigned AW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap_req;
  logic          pix_valid;
  logic [AW-1:0] vga_x, vga_y, rd_addr;
  logic          wr_en, rd_gate, rd_load, busy, sync_err;
  logic [2:0]    state_o;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_frame;
  logic       exp_err;

  fb_access_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .FB_WORDS(FB), .SYNC_TIMEOUT(TO), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .cap_req(cap_req), .pix_valid(pix_valid),
    .vga_x(vga_x), .vga_y(vga_y), .rd_addr(rd_addr),
    .wr_en(wr_en), .rd_gate(rd_gate), .rd_load(rd_load), .busy(busy),
    .state_o(state_o), .frame_cnt(frame_cnt), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected phase: 0 display, 1 debounce, 2 writing, 3 resync.
  task automatic check_outs(input string tag, input int ph, input logic we, input logic ld);
    check_eq({tag, "_state"}, 32'(state_o), 32'(ph));
    check_eq({tag, "_rd_gate"}, 32'(rd_gate), 32'(ph == 0));
    check_eq({tag, "_busy"}, 32'(busy), 32'(ph != 0));
    check_eq({tag, "_wr_en"}, 32'(wr_en), 32'(we));
    check_eq({tag, "_rd_load"}, 32'(rd_load), 32'(ld));
  endtask

  task automatic vga_off_origin();
    vga_x   = AW'($urandom_range(0, 3));
    vga_y   = AW'($urandom_range(0, 3));
    rd_addr = AW'($urandom_range(0, 3));
    if (vga_x == '0 && vga_y == '0 && rd_addr == '0) vga_x = AW'(5);
  endtask

  // One capture attempt: request held for h cycles; origin seen on resync cycle d.
  task automatic capture(input int h, input int pv_mode, input int d, input bit inject,
                         input int abort_words);
    int  words;
    int  cyc;
    bit  pv;
    for (int t = 0; t < h + 3; t++) begin
      @(negedge clk);
      cap_req   = (t < h);
      pix_valid = 1'($urandom_range(0, 1));
      vga_off_origin();
      #1;
      check_outs("arm", (t >= 3) ? 1 : 0, 1'b0, 1'b0);
    end
    if (h < int'(DEB)) begin
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        cap_req   = 1'b0;
        pix_valid = 1'($urandom_range(0, 1));
        #1;
        check_outs("glitch", 0, 1'b0, 1'b0);
        check_eq("glitch_frame", 32'(frame_cnt), 32'(exp_frame));
      end
      return;
    end
    words = 0;
    cyc   = 0;
    while (words < int'(FB)) begin
      @(negedge clk);
      cap_req = inject && cyc >= 1 && cyc <= 4;
      case (pv_mode)
        0:       pv = (cyc % 2 == 1);
        1:       pv = ($urandom_range(0, 3) != 0);
        default: pv = 1'b1;
      endcase
      pix_valid = pv;
      vga_off_origin();
      #1;
      check_outs("write", 2, pv, 1'b0);
      check_eq("write_frame", 32'(frame_cnt), 32'(exp_frame));
      if (pv) words++;
      cyc++;
      if (abort_words != 0 && words == abort_words) begin
        @(negedge clk);
        rst       = 1'b1;
        pix_valid = 1'b1;
        cap_req   = 1'b0;
        #1;
        check_outs("rst_mid", 0, 1'b0, 1'b0);
        check_eq("rst_mid_frame", 32'(frame_cnt), 32'd0);
        check_eq("rst_mid_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        exp_frame = 8'd0;
        exp_err   = 1'b0;
        return;
      end
    end
    exp_frame = exp_frame + 8'd1;
    for (int r = 0; r < int'(TO); r++) begin
      @(negedge clk);
      cap_req   = 1'b0;
      pix_valid = 1'($urandom_range(0, 1));
      if (r == d) begin
        vga_x = '0; vga_y = '0; rd_addr = '0;
      end else begin
        vga_off_origin();
      end
      #1;
      check_outs("resync", 3, 1'b0, 1'b0);
      check_eq("resync_frame", 32'(frame_cnt), 32'(exp_frame));
      check_eq("resync_err", 32'(sync_err), 32'(exp_err));
      if (r == d) break;
      if (r == int'(TO) - 1) exp_err = 1'b1;
    end
    @(negedge clk);
    pix_valid = 1'($urandom_range(0, 1));
    vga_off_origin();
    #1;
    check_outs("reload", 0, 1'b0, 1'b1);
    check_eq("reload_err", 32'(sync_err), 32'(exp_err));
    check_eq("reload_frame", 32'(frame_cnt), 32'(exp_frame));
    @(negedge clk);
    #1;
    check_outs("post", 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cap_req = 1'b0; pix_valid = 1'b1;
    vga_x = '0; vga_y = '0; rd_addr = '0;
    exp_frame = 8'd0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outs("reset", 0, 1'b0, 1'b0);
    check_eq("reset_frame", 32'(frame_cnt), 32'd0);
    check_eq("reset_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; pix_valid = 1'b0;

    // Glitches shorter than the debounce window, including one cycle short.
    capture(1, 1, 0, 1'b0, 0);
    capture(int'(DEB) - 1, 1, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) capture($urandom_range(2, DEB - 2), 1, 0, 1'b0, 0);

    // Long hold, alternate-cycle pixels, origin after a few resync cycles.
    capture(int'(DEB) + 50, 0, 5, 1'b0, 0);
    // Origin and timeout on the same cycle: counts as a match.
    capture(int'(DEB), 1, int'(TO) - 1, 1'b0, 0);
    // Never at origin: forced reload and sticky error.
    capture(int'(DEB), 2, int'(TO) + 5, 1'b0, 0);
    capture(int'(DEB) + 3, 1, 2, 1'b1, 0);
    check_eq("err_sticky", 32'(sync_err), 32'd1);

    // Reset in the middle of a write window.
    capture(int'(DEB), 2, 0, 1'b0, 30);
    check_outs("after_rst", 0, 1'b0, 1'b0);
    capture(int'(DEB), 1, 0, 1'b0, 0);

    // Counter wrap over 256 back-to-back captures (one done just above).
    for (int i = 0; i < 255; i++)
      capture($urandom_range(DEB, DEB + 4), $urandom_range(1, 2),
              $urandom_range(0, TO + 3), 1'($urandom_range(0, 1)), 0);
    check_eq("wrap_frame", 32'(frame_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_access_sequencer.md
Name: fb_access_sequencer

Overview:
Sequences the single SDRAM frame buffer between the capture write port (WR1) and the VGA display read port (RD1). It debounces the user "capture" request and gates pixel writes for exactly one full frame. It then holds off display reads until the VGA raster and the read FIFO address are both at origin, and finally issues a read-FIFO reload. It sits between the top-level key/pixel-valid logic and Sdram_Control, replacing ad-hoc top-level state logic.

Parameters:
DEBOUNCE_CYCLES, 4096, cycles the request must stay high before a capture arms.
FB_WORDS, 65536, words written per captured frame (256x256).
SYNC_TIMEOUT, 1048576, max cycles in RESYNC before a forced reload.
ADDR_W, 16, width of the SDRAM read-address and VGA coordinate inputs.

Ports:
clk  in  1  system clock (sdram_ctrl_clk domain); all other inputs synchronous to it except cap_req.
rst  in  1  asynchronous active-high reset.
cap_req  in  1  capture request, active-high (inverted key), asynchronous; 2-flop synchronised internally.
pix_valid  in  1  write-side pixel strobe, one word per high cycle.
vga_x  in  ADDR_W  current VGA column.
vga_y  in  ADDR_W  current VGA row.
rd_addr  in  ADDR_W  current RD1 FIFO address from SDRAM controller.
wr_en  out  1  WR1 enable = pix_valid gated by WRITE state.
rd_gate  out  1  permits RD1 requests (high only in DISPLAY).
rd_load  out  1  one-cycle RD1_LOAD pulse.
busy  out  1  high in any state other than DISPLAY.
state_o  out  3  encoded state, for LEDR debug.
frame_cnt  out  8  completed captures, wraps 255->0.
sync_err  out  1  sticky; set when RESYNC timed out.

Behaviour:
- Reset (async, any time including mid-write): state=DISPLAY; wr_en=0, rd_gate=1, rd_load=0, busy=0, frame_cnt=0, sync_err=0; all counters 0; sync flops 0.
- Encoding: DISPLAY=0, ARM=1, WRITE=2, RESYNC=3. Values 4-7 are unreachable; if entered, go to DISPLAY.
- state_o, rd_gate and busy are registered and decoded from the state register. wr_en = pix_valid & (state==WRITE), combinational. rd_load is registered.
- DISPLAY: rd_gate=1. If synchronised req (req_s) is 1 -> ARM with deb_cnt=0.
- ARM: deb_cnt increments while req_s=1 and saturates at DEBOUNCE_CYCLES-1.
  - req_s falls with deb_cnt < DEBOUNCE_CYCLES-1 -> DISPLAY (glitch rejected).
  - req_s=0 with deb_cnt == DEBOUNCE_CYCLES-1 -> WRITE with word_cnt=0. Capture starts on release.
- WRITE: word_cnt (ADDR_W+1 bits) increments on each wr_en cycle.
  - On the cycle the FB_WORDS-th word is written (word_cnt==FB_WORDS-1 and wr_en) -> RESYNC; frame_cnt += 1 (mod 256).
  - The next pix_valid is not forwarded. Exactly FB_WORDS wr_en pulses per capture.
  - cap_req is ignored during WRITE.
- RESYNC: rd_gate=0. to_cnt increments each cycle.
  - If vga_x==0 & vga_y==0 & rd_addr==0: rd_load=1 for exactly one cycle; next state DISPLAY.
  - Else if to_cnt==SYNC_TIMEOUT-1: rd_load=1 for one cycle, sync_err<=1, -> DISPLAY.
  - Sync match and timeout on the same cycle: treated as a sync match; sync_err unchanged.
- rd_load is never asserted outside the RESYNC exit cycle. The first DISPLAY cycle has rd_gate=1 and rd_load=1 simultaneously.
- sync_err clears only on rst.
- Latency: req_s lags cap_req by 2 clk. DISPLAY->ARM takes 1 cycle after req_s=1.

Test Plan:
- Reset mid-WRITE after 1000 words -> next cycle state_o=0, wr_en=0 even with pix_valid=1, rd_gate=1, frame_cnt and word_cnt=0.
- Glitch: cap_req high 100 cycles (DEBOUNCE_CYCLES=4096) then low -> state returns 0, no wr_en pulse, frame_cnt stays 0.
- Full capture: cap_req high 5000 cycles then low, pix_valid every 2nd cycle, FB_WORDS=64 (test override) -> exactly 64 wr_en pulses, then state_o=3, frame_cnt=1, 65th pix_valid not forwarded.
- Resync: in RESYNC hold vga_x=5; release to x=0,y=0,rd_addr=0 -> rd_load high exactly 1 cycle, state_o=0 next, sync_err=0.
- Timeout: SYNC_TIMEOUT=32, never reach origin -> rd_load pulse at cycle 32 of RESYNC, sync_err=1, stays 1 through further captures.
- Wrap: 256 back-to-back captures with FB_WORDS=4 -> frame_cnt reads 0 after the 256th; cap_req asserted during WRITE has no effect.
